// File: rtl/spi_slave_regfile_if.sv
// Byte-stream and strobe bundle between the SPI receiver/transmitter and the register bank.
// The master side is the SPI front end and the slave side is the command decoder.
interface spi_slave_regfile_if;
  logic       spi_cs;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       wr_pulse;
  logic [6:0] wr_addr;
  logic       frame_done;

  modport master (
    output spi_cs, rx_data, rx_valid,
    input  tx_data, tx_load, wr_pulse, wr_addr, frame_done
  );

  modport slave (
    input  spi_cs, rx_data, rx_valid,
    output tx_data, tx_load, wr_pulse, wr_addr, frame_done
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI byte-stream command decoder and register bank.
// Splits each chip-select frame into a command byte and data bytes, then writes the bank or feeds readback bytes to the transmitter.
module spi_slave_regfile #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_slave_regfile_if.slave      bus,
  output logic [8*NUM_REGS-1:0]   reg_out
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           cs_sync;
  logic                 cs_end_c;
  logic                 cs_act_c;
  logic [AW-1:0]        addr_q;
  logic                 addr_ld_c;
  logic                 addr_inc_c;
  logic                 wr_c;
  logic                 sched_c;
  logic                 done_c;
  logic                 rd_pend;
  logic                 in_range_c;
  logic [DW-1:0]        rd_val_c;
  logic [8*NUM_REGS-1:0] bank_q;
  logic [DW-1:0]        tx_data_q;
  logic                 tx_load_q;
  logic                 wr_pulse_q;
  logic [AW-1:0]        wr_addr_q;
  logic                 frame_done_q;

  // CS synchroniser: cs_sync[0] is the newest sample, cs_sync[1] the previous one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= 2'b11;
    end else begin
      cs_sync <= {cs_sync[0], bus.spi_cs};
    end
  end

  assign cs_end_c = cs_sync[0] & ~cs_sync[1];
  assign cs_act_c = ~cs_sync[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-byte actions; a CS end always outranks a byte strobe
  always_comb begin
    state_nxt  = state;
    addr_ld_c  = 1'b0;
    addr_inc_c = 1'b0;
    wr_c       = 1'b0;
    sched_c    = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_act_c) begin
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (cs_end_c) begin
          state_nxt = IDLE;
          done_c    = 1'b1;
        end else if (bus.rx_valid) begin
          addr_ld_c = 1'b1;
          if (bus.rx_data[7]) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
            sched_c   = 1'b1;
          end
        end
      end
      WR: begin
        if (cs_end_c) begin
          state_nxt = IDLE;
          done_c    = 1'b1;
        end else if (bus.rx_valid) begin
          wr_c       = 1'b1;
          addr_inc_c = 1'b1;
        end
      end
      RD: begin
        if (cs_end_c) begin
          state_nxt = IDLE;
          done_c    = 1'b1;
        end else if (bus.rx_valid) begin
          addr_inc_c = 1'b1;
          sched_c    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_range_c = {1'b0, addr_q} < 8'(NUM_REGS);

  // Readback mux; addresses past the bank fall through to zero
  always_comb begin
    rd_val_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == AW'(i)) begin
        rd_val_c = bank_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (addr_ld_c) begin
      addr_q <= bus.rx_data[AW-1:0];
    end else if (addr_inc_c) begin
      addr_q <= addr_q + AW'(1);
    end
  end

  // Register bank and write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_pulse_q <= wr_c & in_range_c;
      if (wr_c && in_range_c) begin
        wr_addr_q <= addr_q;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_c && addr_q == AW'(i)) begin
          bank_q[8*i +: 8] <= bus.rx_data;
        end
      end
    end
  end

  // Read load is one edge behind the accepted byte so it sees the updated address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend      <= 1'b0;
      tx_load_q    <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_pend      <= sched_c;
      tx_load_q    <= rd_pend;
      frame_done_q <= done_c;
      if (rd_pend) begin
        tx_data_q <= rd_val_c;
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_load    = tx_load_q;
  assign bus.wr_pulse   = wr_pulse_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.frame_done = frame_done_q;
  assign reg_out        = bank_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomised frame-level bench for spi_slave_regfile against an array-based model of the register map.
// Each frame is predicted from its byte list, then tx/write/done events and the bank are compared.
module tb_spi_slave_regfile;
  localparam int unsigned NUM_REGS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_regfile_if bus();
  logic [8*NUM_REGS-1:0] reg_out;

  spi_slave_regfile #(.NUM_REGS(NUM_REGS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .reg_out (reg_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] mem [NUM_REGS];
  logic [7:0] fq [$];

  logic [7:0] tx_q [$];
  int         tx_cyc_q [$];
  int         wr_q [$];
  int         wr_cyc_q [$];
  int         rx_cyc_q [$];
  int         fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_load) begin
      tx_q.push_back(bus.tx_data);
      tx_cyc_q.push_back(cyc);
    end
    if (bus.wr_pulse) begin
      wr_q.push_back(int'(bus.wr_addr));
      wr_cyc_q.push_back(cyc);
    end
    if (bus.rx_valid) rx_cyc_q.push_back(cyc);
    if (bus.frame_done) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    tx_cyc_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    rx_cyc_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      check_eq($sformatf("%s_reg%0d", tag, i), 64'(reg_out[8*i +: 8]), 64'(mem[i]));
    end
  endtask

  // Drive one CS-low frame; with collide the last byte lands on the CS-rise cycle
  task automatic drive_frame(input logic [7:0] bytes [$], input bit collide);
    int n;
    n = bytes.size();
    bus.spi_cs = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      if (collide && i == n - 1) begin
        bus.spi_cs = 1'b1;
        tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = bytes[i];
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = bytes[i];
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if (!(collide && n > 0)) begin
      repeat (3) tick();
      bus.spi_cs = 1'b1;
    end
    repeat (5) tick();
  endtask

  // Model: command then data bytes, address wraps at 128, out-of-range writes dropped and reads zero
  task automatic run_frame(input string tag, input logic [7:0] bytes [$], input bit collide);
    logic [7:0] eff [$];
    logic [7:0] exp_tx [$];
    int         exp_tx_idx [$];
    int         exp_wr [$];
    int         exp_wr_idx [$];
    logic [7:0] cmd;
    int         a;
    eff = bytes;
    if (collide && eff.size() > 0) void'(eff.pop_back());
    if (eff.size() > 0) begin
      cmd = eff[0];
      a = int'(cmd[6:0]);
      if (cmd[7]) begin
        for (int i = 1; i < eff.size(); i++) begin
          if (a < int'(NUM_REGS)) begin
            mem[a] = eff[i];
            exp_wr.push_back(a);
            exp_wr_idx.push_back(i);
          end
          a = (a + 1) % 128;
        end
      end else begin
        exp_tx.push_back(a < int'(NUM_REGS) ? mem[a] : 8'h00);
        exp_tx_idx.push_back(0);
        for (int i = 1; i < eff.size(); i++) begin
          a = (a + 1) % 128;
          exp_tx.push_back(a < int'(NUM_REGS) ? mem[a] : 8'h00);
          exp_tx_idx.push_back(i);
        end
      end
    end
    clear_mon();
    drive_frame(bytes, collide);
    check_eq({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
      check_eq($sformatf("%s_tx%0d", tag, i), 64'(tx_q[i]), 64'(exp_tx[i]));
      if (exp_tx_idx[i] < rx_cyc_q.size())
        check_eq($sformatf("%s_tx%0d_lat", tag, i), 64'(tx_cyc_q[i] - rx_cyc_q[exp_tx_idx[i]]), 64'(2));
    end
    check_eq({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      check_eq($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_q[i]), 64'(exp_wr[i]));
      if (exp_wr_idx[i] < rx_cyc_q.size())
        check_eq($sformatf("%s_wr%0d_lat", tag, i), 64'(wr_cyc_q[i] - rx_cyc_q[exp_wr_idx[i]]), 64'(1));
    end
    check_eq({tag, "_frame_done"}, 64'(fd_cnt), 64'(1));
    check_bank(tag);
  endtask

  initial begin
    logic [7:0] c;
    int         nd;
    bus.spi_cs   = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < int'(NUM_REGS); i++) mem[i] = 8'h00;

    repeat (3) tick();
    check_eq("rst_reg_out", 64'(reg_out), 64'(0));
    check_eq("rst_tx_data", 64'(bus.tx_data), 64'(0));
    check_eq("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    check_eq("rst_strobes", 64'({bus.tx_load, bus.wr_pulse, bus.frame_done}), 64'(0));
    rst_n = 1'b1;
    repeat (3) tick();

    fq = {8'h82, 8'h11, 8'h22, 8'h33};
    run_frame("wburst", fq, 1'b0);
    check_eq("wburst_reg2", 64'(reg_out[8*2 +: 8]), 64'(8'h11));
    check_eq("wburst_reg4", 64'(reg_out[8*4 +: 8]), 64'(8'h33));

    fq = {8'h03, 8'hFF, 8'hFF};
    run_frame("rburst", fq, 1'b0);
    check_eq("rburst_last", 64'(tx_q.size() == 3 ? tx_q[2] : 8'hEE), 64'(8'h00));

    fq = {8'hFF, 8'hAA, 8'hBB};
    run_frame("wrap", fq, 1'b0);
    check_eq("wrap_reg0", 64'(reg_out[7:0]), 64'(8'hBB));
    fq = {8'h7F};
    run_frame("oor_rd", fq, 1'b0);

    fq = {8'h81, 8'h55};
    run_frame("collide", fq, 1'b1);
    check_eq("collide_reg1", 64'(reg_out[15:8]), 64'(8'h00));

    // Strobes while CS is high must be ignored entirely
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      tick();
      bus.rx_valid = 1'b0;
      tick();
    end
    repeat (3) tick();
    check_eq("idle_events", 64'(tx_q.size() + wr_q.size() + fd_cnt), 64'(0));
    check_bank("idle");

    for (int f = 0; f < 40; f++) begin
      c = 8'($urandom);
      if ($urandom_range(0, 3) == 0) c[6:0] = 7'(120 + $urandom_range(0, 7));
      else c[6:0] = 7'($urandom_range(0, NUM_REGS + 2));
      nd = $urandom_range(0, 5);
      fq = {c};
      for (int i = 0; i < nd; i++) fq.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), fq, $urandom_range(0, 4) == 0);
    end

    // Reset in the middle of a write frame
    bus.spi_cs = 1'b0;
    repeat (3) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h81;
    tick();
    bus.rx_data  = 8'h12;
    tick();
    bus.rx_valid = 1'b0;
    check_eq("abort_pre_wr", 64'(bus.wr_pulse), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("abort_reg_out", 64'(reg_out), 64'(0));
    check_eq("abort_strobes", 64'({bus.tx_load, bus.wr_pulse, bus.frame_done}), 64'(0));
    check_eq("abort_wr_addr", 64'(bus.wr_addr), 64'(0));
    for (int i = 0; i < int'(NUM_REGS); i++) mem[i] = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    fq = {8'h80, 8'h5A};
    run_frame("post_rst", fq, 1'b0);
    check_eq("post_rst_reg0", 64'(reg_out[7:0]), 64'(8'h5A));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
